// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle control FSM and the datapath.
// master = control FSM (drives selects/enables), slave = datapath side.
interface mc_control_fsm_if;
  logic [5:0] op_code;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_write;
  logic       ir_write;
  logic       i_or_d;
  logic [1:0] mem_to_reg;
  logic [1:0] reg_dst;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [2:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       pc_write;
  logic       pc_write_cond;
  logic       branch_ne;
  logic       illegal_op;
  logic [3:0] state_dbg;

  modport master (
    input  op_code, funct, zero, mem_ready,
    output mem_write, ir_write, i_or_d, mem_to_reg, reg_dst, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_source, pc_write, pc_write_cond,
           branch_ne, illegal_op, state_dbg
  );

  modport slave (
    output op_code, funct, zero, mem_ready,
    input  mem_write, ir_write, i_or_d, mem_to_reg, reg_dst, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_source, pc_write, pc_write_cond,
           branch_ne, illegal_op, state_dbg
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control FSM with configurable memory wait (counter or mem_ready),
// BEQ/BNE, J/JAL/JR and a sticky illegal-opcode trap. Outputs are decoded from state.
module mc_control_fsm #(
  parameter int MEM_WAIT        = 1,
  parameter int USE_MEM_READY   = 0,
  parameter int TRAP_ON_ILLEGAL = 1
) (
  input  logic               clk,
  input  logic               rst,
  mc_control_fsm_if.master   bus
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,  DECODE = 4'd1,  MEM_ADDR = 4'd2,  MEM_READ = 4'd3,
    MEM_WB    = 4'd4,  MEM_WRITE = 4'd5, EXEC_R = 4'd6,  WB_R     = 4'd7,
    BRANCH    = 4'd8,  EXEC_I = 4'd9,  WB_I     = 4'd10, JUMP     = 4'd11,
    JR        = 4'd12, JAL    = 4'd13, TRAP     = 4'd14
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

  state_t     state, next_state;
  logic [3:0] wait_cnt;
  logic       illegal_q;
  logic       mem_done;
  logic       unused_zero;

  // Branch resolution happens in the datapath; the flag is carried only for completeness.
  assign unused_zero = bus.zero;

  assign mem_done = (USE_MEM_READY != 0) ? bus.mem_ready : (wait_cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= FETCH;
      wait_cnt  <= WAIT_INIT;
      illegal_q <= 1'b0;
    end else begin
      state <= next_state;
      // Reload on every state change so each memory state starts a fresh wait.
      if (next_state != state)
        wait_cnt <= WAIT_INIT;
      else if (wait_cnt != 4'd0)
        wait_cnt <= wait_cnt - 4'd1;
      if (next_state == TRAP)
        illegal_q <= 1'b1;
    end
  end

  always_comb begin
    next_state        = state;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_to_reg    = 2'b00;
    bus.reg_dst       = 2'b00;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 2'b00;
    bus.alu_src_b     = 3'b000;
    bus.alu_op        = 2'b00;
    bus.pc_source     = 2'b00;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.branch_ne     = 1'b0;

    unique case (state)
      FETCH: begin
        bus.alu_src_b = 3'b001;
        if (mem_done) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          next_state   = DECODE;
        end
      end
      DECODE: begin
        bus.alu_src_b = 3'b011;
        unique case (bus.op_code)
          6'h00:                      next_state = (bus.funct == 6'h08) ? JR : EXEC_R;
          6'h02:                      next_state = JUMP;
          6'h03:                      next_state = JAL;
          6'h04, 6'h05:               next_state = BRANCH;
          6'h08, 6'h0A, 6'h0C,
          6'h0D, 6'h0E:               next_state = EXEC_I;
          6'h23, 6'h2B:               next_state = MEM_ADDR;
          default:                    next_state = (TRAP_ON_ILLEGAL != 0) ? TRAP : FETCH;
        endcase
      end
      EXEC_R: begin
        bus.alu_op = 2'b10;
        // Shifts take the B register through port A and shamt through port B.
        if (bus.funct == 6'h00 || bus.funct == 6'h02 || bus.funct == 6'h03) begin
          bus.alu_src_a = 2'b10;
          bus.alu_src_b = 3'b100;
        end else begin
          bus.alu_src_a = 2'b01;
          bus.alu_src_b = 3'b000;
        end
        next_state = WB_R;
      end
      WB_R: begin
        bus.reg_dst   = 2'b01;
        bus.reg_write = 1'b1;
        next_state    = FETCH;
      end
      EXEC_I: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 3'b010;
        bus.alu_op    = 2'b11;
        next_state    = WB_I;
      end
      WB_I: begin
        bus.reg_write = 1'b1;
        next_state    = FETCH;
      end
      MEM_ADDR: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 3'b010;
        next_state    = (bus.op_code == 6'h2B) ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        bus.i_or_d = 1'b1;
        if (mem_done) next_state = MEM_WB;
      end
      MEM_WB: begin
        bus.mem_to_reg = 2'b01;
        bus.reg_write  = 1'b1;
        next_state     = FETCH;
      end
      MEM_WRITE: begin
        bus.i_or_d = 1'b1;
        if (mem_done) begin
          bus.mem_write = 1'b1;
          next_state    = FETCH;
        end
      end
      BRANCH: begin
        bus.alu_src_a     = 2'b01;
        bus.alu_op        = 2'b01;
        bus.pc_source     = 2'b01;
        bus.pc_write_cond = 1'b1;
        bus.branch_ne     = (bus.op_code == 6'h05);
        next_state        = FETCH;
      end
      JUMP: begin
        bus.pc_source = 2'b10;
        bus.pc_write  = 1'b1;
        next_state    = FETCH;
      end
      JR: begin
        bus.pc_source = 2'b11;
        bus.pc_write  = 1'b1;
        next_state    = FETCH;
      end
      JAL: begin
        bus.pc_source  = 2'b10;
        bus.pc_write   = 1'b1;
        bus.reg_dst    = 2'b10;
        bus.mem_to_reg = 2'b10;
        bus.reg_write  = 1'b1;
        next_state     = FETCH;
      end
      TRAP:    next_state = TRAP;
      default: next_state = FETCH;
    endcase

    // Reset aborts the instruction in flight without letting any write escape.
    if (!rst) begin
      bus.mem_write     = 1'b0;
      bus.ir_write      = 1'b0;
      bus.reg_write     = 1'b0;
      bus.pc_write      = 1'b0;
      bus.pc_write_cond = 1'b0;
    end
  end

  assign bus.illegal_op = illegal_q;
  assign bus.state_dbg  = state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: four parameterisations share one stimulus stream.
module tb_mc_control_fsm;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] op_code = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       mem_ready = 1'b0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  mc_control_fsm_if if_w1 ();
  mc_control_fsm_if if_w2 ();
  mc_control_fsm_if if_rdy ();
  mc_control_fsm_if if_nt ();

  assign if_w1.op_code  = op_code;  assign if_w1.funct  = funct;
  assign if_w1.zero     = 1'b0;     assign if_w1.mem_ready = mem_ready;
  assign if_w2.op_code  = op_code;  assign if_w2.funct  = funct;
  assign if_w2.zero     = 1'b0;     assign if_w2.mem_ready = mem_ready;
  assign if_rdy.op_code = op_code;  assign if_rdy.funct = funct;
  assign if_rdy.zero    = 1'b0;     assign if_rdy.mem_ready = mem_ready;
  assign if_nt.op_code  = op_code;  assign if_nt.funct  = funct;
  assign if_nt.zero     = 1'b0;     assign if_nt.mem_ready = mem_ready;

  mc_control_fsm #(.MEM_WAIT(1), .USE_MEM_READY(0), .TRAP_ON_ILLEGAL(1))
    u_w1 (.clk(clk), .rst(rst), .bus(if_w1));
  mc_control_fsm #(.MEM_WAIT(2), .USE_MEM_READY(0), .TRAP_ON_ILLEGAL(1))
    u_w2 (.clk(clk), .rst(rst), .bus(if_w2));
  mc_control_fsm #(.MEM_WAIT(1), .USE_MEM_READY(1), .TRAP_ON_ILLEGAL(1))
    u_rdy (.clk(clk), .rst(rst), .bus(if_rdy));
  mc_control_fsm #(.MEM_WAIT(1), .USE_MEM_READY(0), .TRAP_ON_ILLEGAL(0))
    u_nt (.clk(clk), .rst(rst), .bus(if_nt));

  // Hold reset across one rising edge, release just after it; cycle 1 is the next negedge.
  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    op_code = 6'h08; funct = 6'h00; mem_ready = 1'b1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (if_w1.state_dbg !== 4'd0) begin errors++; $display("FAIL rst_state got %0d want 0", if_w1.state_dbg); end
    checks++; if (if_w1.illegal_op !== 1'b0) begin errors++; $display("FAIL rst_illegal got %b want 0", if_w1.illegal_op); end
    checks++; if (if_rdy.ir_write !== 1'b0) begin errors++; $display("FAIL rst_gate_ir_write got %b want 0", if_rdy.ir_write); end
    checks++; if (if_rdy.pc_write !== 1'b0) begin errors++; $display("FAIL rst_gate_pc_write got %b want 0", if_rdy.pc_write); end
    @(posedge clk); #1;
    rst = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    checks++; if (if_w1.alu_src_b !== 3'b001) begin errors++; $display("FAIL rst_fetch_b got %b want 001", if_w1.alu_src_b); end
  endtask

  task automatic test_addi();
    op_code = 6'h08; funct = 6'h00;
    do_reset();
    @(negedge clk);
    checks++; if (if_w1.state_dbg !== 4'd0 || if_w1.ir_write !== 1'b0 || if_w1.pc_write !== 1'b0) begin
      errors++; $display("FAIL addi_c1 got st=%0d ir=%b pc=%b want 0/0/0", if_w1.state_dbg, if_w1.ir_write, if_w1.pc_write); end
    @(negedge clk);
    checks++; if (if_w1.state_dbg !== 4'd0 || if_w1.ir_write !== 1'b1 || if_w1.pc_write !== 1'b1) begin
      errors++; $display("FAIL addi_c2 got st=%0d ir=%b pc=%b want 0/1/1", if_w1.state_dbg, if_w1.ir_write, if_w1.pc_write); end
    @(negedge clk);
    checks++; if (if_w1.state_dbg !== 4'd1 || if_w1.alu_src_b !== 3'b011) begin
      errors++; $display("FAIL addi_decode got st=%0d b=%b want 1/011", if_w1.state_dbg, if_w1.alu_src_b); end
    @(negedge clk);
    checks++; if (if_w1.state_dbg !== 4'd9 || if_w1.alu_src_b !== 3'b010 || if_w1.alu_op !== 2'b11 || if_w1.alu_src_a !== 2'b01) begin
      errors++; $display("FAIL addi_exec got st=%0d a=%b b=%b op=%b want 9/01/010/11", if_w1.state_dbg, if_w1.alu_src_a, if_w1.alu_src_b, if_w1.alu_op); end
    @(negedge clk);
    checks++; if (if_w1.state_dbg !== 4'd10 || if_w1.reg_write !== 1'b1 || if_w1.reg_dst !== 2'b00) begin
      errors++; $display("FAIL addi_wb got st=%0d rw=%b dst=%b want 10/1/00", if_w1.state_dbg, if_w1.reg_write, if_w1.reg_dst); end
    @(negedge clk);
    checks++; if (if_w1.state_dbg !== 4'd0) begin errors++; $display("FAIL addi_back got %0d want 0", if_w1.state_dbg); end
  endtask

  task automatic test_rtype_shift();
    op_code = 6'h00; funct = 6'h02;
    do_reset();
    repeat (4) @(negedge clk);
    checks++; if (if_w1.state_dbg !== 4'd6 || if_w1.alu_src_a !== 2'b10 || if_w1.alu_src_b !== 3'b100 || if_w1.alu_op !== 2'b10) begin
      errors++; $display("FAIL srl_exec got st=%0d a=%b b=%b op=%b want 6/10/100/10", if_w1.state_dbg, if_w1.alu_src_a, if_w1.alu_src_b, if_w1.alu_op); end
    @(negedge clk);
    checks++; if (if_w1.state_dbg !== 4'd7 || if_w1.reg_dst !== 2'b01 || if_w1.reg_write !== 1'b1) begin
      errors++; $display("FAIL srl_wb got st=%0d dst=%b rw=%b want 7/01/1", if_w1.state_dbg, if_w1.reg_dst, if_w1.reg_write); end
  endtask

  task automatic test_lw_wait2();
    logic [3:0] exp_st [10] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    op_code = 6'h23; funct = 6'h00;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (if_w2.state_dbg !== exp_st[i]) begin
        errors++; $display("FAIL lw_seq cycle %0d got %0d want %0d", i + 1, if_w2.state_dbg, exp_st[i]); end
      if (i == 8) begin
        checks++; if (if_w2.mem_to_reg !== 2'b01 || if_w2.reg_write !== 1'b1) begin
          errors++; $display("FAIL lw_wb got m2r=%b rw=%b want 01/1", if_w2.mem_to_reg, if_w2.reg_write); end
      end
    end
  endtask

  task automatic test_sw_ready();
    int pulses = 0;
    op_code = 6'h2B; funct = 6'h00; mem_ready = 1'b1;
    do_reset();
    @(negedge clk);
    checks++; if (if_rdy.ir_write !== 1'b1) begin errors++; $display("FAIL sw_fetch_ir got %b want 1", if_rdy.ir_write); end
    @(posedge clk); #1; mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (if_rdy.state_dbg !== 4'd2) begin errors++; $display("FAIL sw_addr got %0d want 2", if_rdy.state_dbg); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (if_rdy.mem_write === 1'b1) pulses++;
      checks++; if (if_rdy.state_dbg !== 4'd5 || if_rdy.mem_write !== 1'b0) begin
        errors++; $display("FAIL sw_wait cycle %0d got st=%0d mw=%b want 5/0", i, if_rdy.state_dbg, if_rdy.mem_write); end
    end
    @(posedge clk); #1; mem_ready = 1'b1;
    @(negedge clk);
    if (if_rdy.mem_write === 1'b1) pulses++;
    checks++; if (if_rdy.state_dbg !== 4'd5 || if_rdy.mem_write !== 1'b1) begin
      errors++; $display("FAIL sw_done got st=%0d mw=%b want 5/1", if_rdy.state_dbg, if_rdy.mem_write); end
    @(posedge clk); #1; mem_ready = 1'b0;
    @(negedge clk);
    if (if_rdy.mem_write === 1'b1) pulses++;
    checks++; if (if_rdy.state_dbg !== 4'd0) begin errors++; $display("FAIL sw_back got %0d want 0", if_rdy.state_dbg); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL sw_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_branch(input logic [5:0] op, input logic exp_ne);
    op_code = op; funct = 6'h00;
    do_reset();
    repeat (4) @(negedge clk);
    checks++; if (if_w1.state_dbg !== 4'd8 || if_w1.pc_write_cond !== 1'b1 || if_w1.branch_ne !== exp_ne ||
                  if_w1.alu_op !== 2'b01 || if_w1.pc_source !== 2'b01 || if_w1.pc_write !== 1'b0) begin
      errors++; $display("FAIL branch op=%h got st=%0d pwc=%b ne=%b aop=%b psrc=%b pw=%b want 8/1/%b/01/01/0",
                         op, if_w1.state_dbg, if_w1.pc_write_cond, if_w1.branch_ne, if_w1.alu_op, if_w1.pc_source, if_w1.pc_write, exp_ne); end
    @(negedge clk);
    checks++; if (if_w1.state_dbg !== 4'd0) begin errors++; $display("FAIL branch_back op=%h got %0d want 0", op, if_w1.state_dbg); end
  endtask

  task automatic test_jal_jr();
    op_code = 6'h03; funct = 6'h00;
    do_reset();
    repeat (4) @(negedge clk);
    checks++; if (if_w1.state_dbg !== 4'd13 || if_w1.pc_write !== 1'b1 || if_w1.reg_write !== 1'b1 ||
                  if_w1.reg_dst !== 2'b10 || if_w1.mem_to_reg !== 2'b10 || if_w1.pc_source !== 2'b10) begin
      errors++; $display("FAIL jal got st=%0d pw=%b rw=%b dst=%b m2r=%b psrc=%b want 13/1/1/10/10/10",
                         if_w1.state_dbg, if_w1.pc_write, if_w1.reg_write, if_w1.reg_dst, if_w1.mem_to_reg, if_w1.pc_source); end
    op_code = 6'h00; funct = 6'h08;
    do_reset();
    repeat (4) @(negedge clk);
    checks++; if (if_w1.state_dbg !== 4'd12 || if_w1.pc_source !== 2'b11 || if_w1.pc_write !== 1'b1) begin
      errors++; $display("FAIL jr got st=%0d psrc=%b pw=%b want 12/11/1", if_w1.state_dbg, if_w1.pc_source, if_w1.pc_write); end
  endtask

  task automatic test_illegal();
    op_code = 6'h3F; funct = 6'h00;
    do_reset();
    repeat (4) @(negedge clk);
    checks++; if (if_w1.state_dbg !== 4'd14 || if_w1.illegal_op !== 1'b1) begin
      errors++; $display("FAIL trap_enter got st=%0d ill=%b want 14/1", if_w1.state_dbg, if_w1.illegal_op); end
    checks++; if (if_nt.state_dbg !== 4'd0 || if_nt.illegal_op !== 1'b0) begin
      errors++; $display("FAIL notrap got st=%0d ill=%b want 0/0", if_nt.state_dbg, if_nt.illegal_op); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (if_w1.state_dbg !== 4'd14 || if_w1.illegal_op !== 1'b1 || if_w1.reg_write !== 1'b0 || if_w1.pc_write !== 1'b0) begin
        errors++; $display("FAIL trap_hold cycle %0d got st=%0d ill=%b rw=%b pw=%b want 14/1/0/0",
                           i, if_w1.state_dbg, if_w1.illegal_op, if_w1.reg_write, if_w1.pc_write); end
    end
    op_code = 6'h08;
    do_reset();
    @(negedge clk);
    checks++; if (if_w1.state_dbg !== 4'd0 || if_w1.illegal_op !== 1'b0) begin
      errors++; $display("FAIL trap_clear got st=%0d ill=%b want 0/0", if_w1.state_dbg, if_w1.illegal_op); end
  endtask

  task automatic test_reset_abort();
    op_code = 6'h2B; funct = 6'h00; mem_ready = 1'b1;
    do_reset();
    @(negedge clk);
    @(posedge clk); #1; mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (if_rdy.state_dbg !== 4'd5) begin errors++; $display("FAIL abort_setup got %0d want 5", if_rdy.state_dbg); end
    @(posedge clk); #1; rst = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    checks++; if (if_rdy.mem_write !== 1'b0) begin errors++; $display("FAIL abort_gate got mw=%b want 0", if_rdy.mem_write); end
    @(posedge clk); #1; rst = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    checks++; if (if_rdy.state_dbg !== 4'd0 || if_rdy.mem_write !== 1'b0) begin
      errors++; $display("FAIL abort_next got st=%0d mw=%b want 0/0", if_rdy.state_dbg, if_rdy.mem_write); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_rtype_shift();
    test_lw_wait2();
    test_sw_ready();
    test_branch(6'h05, 1'b1);
    test_branch(6'h04, 1'b0);
    test_jal_jr();
    test_illegal();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
